// File: rtl/wb_reg_file_if.sv
// Write-back register file bus: commit port from EX/WB, two decode read ports,
// and the debug status outputs (written bitmap, commit counter).
// master = pipeline/decode side, slave = register file.
interface wb_reg_file_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16
);
  logic                WB_Reg_Write;
  logic [ADDR_W-1:0]   WB_RD;
  logic [DATA_W-1:0]   WB_Data;
  logic [ADDR_W-1:0]   RS1_Addr;
  logic [ADDR_W-1:0]   RS2_Addr;
  logic [DATA_W-1:0]   Read_Data1;
  logic [DATA_W-1:0]   Read_Data2;
  logic [NUM_REGS-1:0] Written_Map;
  logic [CNT_W-1:0]    Commit_Count;

  modport master (
    output WB_Reg_Write, WB_RD, WB_Data, RS1_Addr, RS2_Addr,
    input  Read_Data1, Read_Data2, Written_Map, Commit_Count
  );

  modport slave (
    input  WB_Reg_Write, WB_RD, WB_Data, RS1_Addr, RS2_Addr,
    output Read_Data1, Read_Data2, Written_Map, Commit_Count
  );
endinterface

// File: rtl/wb_reg_file.sv
// Write-back stage register file: commits EX/WB results into NUM_REGS x DATA_W
// registers and serves two combinational read ports to decode.
// Ports: Clk, Reset (async, active-low), bus (wb_reg_file_if.slave: commit
// port, RS1/RS2 read ports, Written_Map, saturating Commit_Count).
// Latency: commit visible from the array one cycle after the edge; reads are
// combinational. No backpressure: every cycle with WB_Reg_Write=1 commits.
// Optional: define WB_REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module wb_reg_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  wb_reg_file_if.slave  bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] written_map_q, written_map_d;
  logic [CNT_W-1:0]    commit_count_q, commit_count_d;

  // Status next-state: map bit sticks once set; counter stops at all-ones.
  always_comb begin
    written_map_d  = written_map_q;
    commit_count_d = commit_count_q;
    if (bus.WB_Reg_Write) begin
      written_map_d[bus.WB_RD] = 1'b1;
      if (commit_count_q != {CNT_W{1'b1}}) begin
        commit_count_d = commit_count_q + CNT_W'(1);
      end
    end
  end

  // Registers reset to their own index so a bring-up read is self-identifying.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
    end else if (bus.WB_Reg_Write) begin
      regs_q[bus.WB_RD] <= bus.WB_Data;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      written_map_q  <= '0;
      commit_count_q <= '0;
    end else begin
      written_map_q  <= written_map_d;
      commit_count_q <= commit_count_d;
    end
  end

`ifdef WB_REGFILE_BYPASS_EN
  // Gated by Reset so that reads during reset always show the reset values.
  logic bypass1, bypass2;
  assign bypass1 = Reset && bus.WB_Reg_Write && (bus.RS1_Addr == bus.WB_RD);
  assign bypass2 = Reset && bus.WB_Reg_Write && (bus.RS2_Addr == bus.WB_RD);
  assign bus.Read_Data1 = bypass1 ? bus.WB_Data : regs_q[bus.RS1_Addr];
  assign bus.Read_Data2 = bypass2 ? bus.WB_Data : regs_q[bus.RS2_Addr];
`else
  assign bus.Read_Data1 = regs_q[bus.RS1_Addr];
  assign bus.Read_Data2 = regs_q[bus.RS2_Addr];
`endif

  assign bus.Written_Map  = written_map_q;
  assign bus.Commit_Count = commit_count_q;

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Write-back stage register file. Consumes the EX/WB pipeline register outputs (write enable, destination index, ALU result) and commits them to an 8-entry x 8-bit architectural register file.
- Provides two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Keeps a per-register "written since reset" bitmap and a saturating commit counter for debug and verification.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register index width
- NUM_REGS, 8, number of registers; must equal 2**ADDR_W
- CNT_W, 16, width of the commit counter

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- WB_Reg_Write  input  1  commit enable from the EX/WB register
- WB_RD  input  ADDR_W  destination register index
- WB_Data  input  DATA_W  result to commit
- RS1_Addr  input  ADDR_W  read port 1 index
- RS2_Addr  input  ADDR_W  read port 2 index
- Read_Data1  output  DATA_W  read port 1 data (combinational)
- Read_Data2  output  DATA_W  read port 2 data (combinational)
- Written_Map  output  NUM_REGS  bit i set once register i has been committed since reset
- Commit_Count  output  CNT_W  number of commits since reset, saturating

Behaviour:
- Reset is asynchronous and active-low. Reset=0 forces, immediately and independent of Clk:
  - every register i to i (zero-extended to DATA_W);
  - Written_Map to 0;
  - Commit_Count to 0.
- Reset deasserting mid-operation: no commit occurs on an edge at which Reset=0. Normal operation resumes at the first rising edge with Reset=1.
- Commit, on a rising Clk edge with WB_Reg_Write=1:
  - reg[WB_RD] <= WB_Data;
  - Written_Map[WB_RD] <= 1;
  - Commit_Count increments by 1, saturating at all-ones with no wrap.
- With WB_Reg_Write=0: registers, Written_Map and Commit_Count hold.
- No register is hardwired. R0 is writable like any other register.
- Write latency: the new value is visible from the stored array the cycle after the edge.
- Reads are purely combinational from the array and RS addresses. With bypass compiled in (see Optional Feature):
  - if WB_Reg_Write=1 and RSx_Addr==WB_RD, Read_DataX = WB_Data in the same cycle;
  - both ports may bypass simultaneously when RS1_Addr==RS2_Addr==WB_RD.
- Bypass applies only while Reset=1. While Reset=0, reads return the reset values.
- WB_RD, RS1_Addr and RS2_Addr are always in range (NUM_REGS=2**ADDR_W), so no out-of-range case exists.
- Repeated writes to the same register overwrite it. Written_Map stays 1. Each write counts as a commit.
- X on WB_Reg_Write is a testbench error. The bench asserts it is never X while Reset=1.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read bypass as described in Behaviour. Decode sees a result in the same cycle it commits, closing the 1-cycle RAW hazard across the EX/WB boundary.
- Undefined: reads return only stored array contents. A read of WB_RD during a commit cycle returns the old value, and the hazard must be handled by stall or forwarding elsewhere.

Test Plan:
- Reset check: pulse Reset low for 2 cycles, then read all 8 indices on both ports -> reg i returns i, Written_Map=8'h00, Commit_Count=0.
- Basic commit: write R3=8'hA5 (WB_Reg_Write=1, WB_RD=3), then hold WB_Reg_Write=0 -> next cycle Read_Data1(RS1=3)=8'hA5, Written_Map=8'h08, Commit_Count=1. Further idle cycles leave all three unchanged.
- Bypass, same cycle, RS1=RS2=5, WB_RD=5, WB_Data=8'h3C:
  - bypass defined: both ports show 8'h3C in that cycle;
  - bypass undefined: both ports show 8'h05 in that cycle, then 8'h3C after the edge.
- Back-to-back same register: write R7=8'h11 then R7=8'h22 on consecutive edges -> R7 reads 8'h22, Written_Map=8'h80, Commit_Count=2.
- Async reset mid-stream: write R2=8'hFF, then drop Reset between clock edges while WB_Reg_Write=1 -> without waiting for a clock edge, R2 reads 8'h02, Written_Map=0 and Commit_Count=0. No commit is taken while Reset=0.
- Saturation: with CNT_W=4, perform 20 commits -> Commit_Count reaches 4'hF and stays there. Registers still update on each commit.
